// File: rtl/guitar_effect_fifo_if.sv
// Avalon-MM slave bus bundle for guitar_effect_fifo, plus its level interrupt.
interface guitar_effect_fifo_if;
    logic [4:0]  avl_address;
    logic        avl_read;
    logic        avl_write;
    logic [31:0] avl_writedata;
    logic [31:0] avl_readdata;
    logic        irq;

    modport master (
        output avl_address, avl_read, avl_write, avl_writedata,
        input  avl_readdata, irq
    );

    modport slave (
        input  avl_address, avl_read, avl_write, avl_writedata,
        output avl_readdata, irq
    );
endinterface

// File: rtl/guitar_effect_fifo.sv
// Buffered guitar effect: input FIFO -> gain -> clip -> output FIFO,
// processed at an internal audio-rate tick, with an Avalon-MM register map.

// Plain synchronous FIFO; a pop and a push in the same cycle both happen,
// so a full FIFO still accepts a push when it is also being popped.
module guitar_effect_fifo_buf #(
    parameter int W     = 16,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_pop;
    logic          do_push;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // storage; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

module guitar_effect_fifo #(
    parameter int DATA_W     = 16,
    parameter int GAIN_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int TICK_DIV   = 100,
    parameter int IRQ_LEVEL  = 4
) (
    input logic clk,
    input logic reset,
    guitar_effect_fifo_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = DATA_W + GAIN_W + 1;
    localparam int TW = $clog2(TICK_DIV);
    localparam logic signed [PW-1:0] SMAX = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PW-1:0] SMIN = ~SMAX;

    logic [GAIN_W-1:0] gain_r;
    logic [DATA_W-2:0] boost_r;
    logic [1:0]        mode_r;
    logic              en_r, irq_en_r, in_ovf, out_unf;
    logic [TW-1:0]     tick_cnt;
    logic              tick, issue, in_push, out_pop;
    logic [DATA_W-1:0] in_dout, out_dout, out_din;
    logic [CW-1:0]     in_count, out_count;
    logic              in_empty, in_full, out_empty, out_full;
    logic              s1_valid;
    logic signed [PW-1:0] s1_prod, prod_c, q_c, hi_c, clip_c, sat_c;
    logic [DATA_W-1:0] s1_sample;
    logic [1:0]        s1_mode;
    logic [31:0]       rd_mux;
    logic              unused_wdata;

    assign unused_wdata = ^bus.avl_writedata[31:DATA_W];

    assign in_push = bus.avl_write & (bus.avl_address == 5'h06);
    assign out_pop = bus.avl_read  & (bus.avl_address == 5'h05);
    assign tick    = (tick_cnt == '0);
    assign issue   = tick & en_r & ~in_empty
                   & ((int'(out_count) + int'(s1_valid)) < FIFO_DEPTH);

    guitar_effect_fifo_buf #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_in_fifo (
        .clk(clk), .reset(reset), .push(in_push), .pop(issue),
        .din(bus.avl_writedata[DATA_W-1:0]), .dout(in_dout),
        .count(in_count), .empty(in_empty), .full(in_full)
    );

    guitar_effect_fifo_buf #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_out_fifo (
        .clk(clk), .reset(reset), .push(s1_valid), .pop(out_pop),
        .din(out_din), .dout(out_dout),
        .count(out_count), .empty(out_empty), .full(out_full)
    );

    // tick timer: counts down cycles remaining until the next sample tick
    always_ff @(posedge clk) begin
        if (!reset || tick) tick_cnt <= TW'(TICK_DIV - 1);
        else                tick_cnt <= tick_cnt - TW'(1);
    end

    // register writes and sticky error flags (a new event wins over a clear)
    always_ff @(posedge clk) begin
        if (!reset) begin
            gain_r   <= GAIN_W'(16);
            boost_r  <= '1;
            mode_r   <= '0;
            en_r     <= 1'b0;
            irq_en_r <= 1'b0;
            in_ovf   <= 1'b0;
            out_unf  <= 1'b0;
        end else begin
            if (bus.avl_write) begin
                case (bus.avl_address)
                    5'h01: gain_r  <= bus.avl_writedata[GAIN_W-1:0];
                    5'h02: boost_r <= bus.avl_writedata[DATA_W-2:0];
                    5'h03: begin
                        if (bus.avl_writedata[4]) in_ovf  <= 1'b0;
                        if (bus.avl_writedata[5]) out_unf <= 1'b0;
                    end
                    5'h04: begin
                        mode_r   <= bus.avl_writedata[1:0];
                        en_r     <= bus.avl_writedata[2];
                        irq_en_r <= bus.avl_writedata[3];
                    end
                    default: ;
                endcase
            end
            if (in_push && in_full && !issue) in_ovf  <= 1'b1;
            if (out_pop && out_empty)         out_unf <= 1'b1;
        end
    end

    assign prod_c = PW'($signed(in_dout)) * PW'($signed({1'b0, gain_r}));

    // stage 1: capture the product plus the mode in force when the sample left the FIFO
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid  <= 1'b0;
            s1_prod   <= '0;
            s1_sample <= '0;
            s1_mode   <= '0;
        end else begin
            s1_valid <= issue;
            if (issue) begin
                s1_prod   <= prod_c;
                s1_sample <= in_dout;
                s1_mode   <= mode_r;
            end
        end
    end

    // stage 2: scale back by the 4 fractional gain bits, clip, then saturate
    always_comb begin
        hi_c   = PW'($signed({1'b0, boost_r}));
        q_c    = s1_prod >>> 4;
        clip_c = q_c;
        case (s1_mode)
            2'd0: clip_c = PW'($signed(s1_sample));
            2'd1: begin
                if (q_c > hi_c)       clip_c = hi_c;
                else if (q_c < -hi_c) clip_c = -hi_c;
            end
            2'd2: begin
                if (q_c > hi_c)                clip_c = hi_c;
                else if (q_c < -(hi_c >>> 1)) clip_c = -(hi_c >>> 1);
            end
            default: clip_c = '0;
        endcase
        sat_c = clip_c;
        if (clip_c > SMAX)      sat_c = SMAX;
        else if (clip_c < SMIN) sat_c = SMIN;
        out_din = sat_c[DATA_W-1:0];
    end

    // read-data decode
    always_comb begin
        rd_mux = '0;
        case (bus.avl_address)
            5'h01: rd_mux = 32'(gain_r);
            5'h02: rd_mux = 32'(boost_r);
            5'h03: rd_mux = {8'h00, 8'(out_count), 8'(in_count), 2'b00, out_unf, in_ovf,
                             out_full, out_empty, in_full, in_empty};
            5'h04: rd_mux = {28'h0, irq_en_r, en_r, mode_r};
            5'h05: if (!out_empty) rd_mux = {{(32-DATA_W){out_dout[DATA_W-1]}}, out_dout};
            default: rd_mux = '0;
        endcase
    end

    // registered read data (held between reads) and level interrupt
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.avl_readdata <= '0;
            bus.irq          <= 1'b0;
        end else begin
            if (bus.avl_read) bus.avl_readdata <= rd_mux;
            bus.irq <= irq_en_r & (int'(out_count) >= IRQ_LEVEL);
        end
    end
endmodule

// File: tb/tb_guitar_effect_fifo.sv
// Directed bench for guitar_effect_fifo with an expected-output scoreboard.
module tb_guitar_effect_fifo;
    localparam int TICK = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cur_gain = 16;
    int   cur_boost = 32767;
    int   cur_mode = 0;
    logic [31:0] sb[$];
    logic [31:0] rd;

    guitar_effect_fifo_if bus();

    guitar_effect_fifo #(
        .DATA_W(16), .GAIN_W(8), .FIFO_DEPTH(8), .TICK_DIV(TICK), .IRQ_LEVEL(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input int s, input int g, input int b, input int m);
        int q;
        case (m)
            0: q = s;
            1: begin
                q = (s * g) >>> 4;
                if (q > b) q = b; else if (q < -b) q = -b;
            end
            2: begin
                q = (s * g) >>> 4;
                if (q > b) q = b; else if (q < -(b >> 1)) q = -(b >> 1);
            end
            default: q = 0;
        endcase
        if (q > 32767) q = 32767; else if (q < -32768) q = -32768;
        return 32'(q);
    endfunction

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.avl_address   = a;
        bus.avl_writedata = d;
        bus.avl_write     = 1'b1;
        @(negedge clk);
        bus.avl_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.avl_address = a;
        bus.avl_read    = 1'b1;
        @(negedge clk);
        bus.avl_read    = 1'b0;
        d = bus.avl_readdata;
    endtask

    task automatic set_cfg(input int g, input int b, input int ctrl);
        bus_write(5'h01, 32'(g));
        bus_write(5'h02, 32'(b));
        bus_write(5'h04, 32'(ctrl));
        cur_gain = g; cur_boost = b; cur_mode = ctrl & 3;
    endtask

    task automatic push_sample(input int s, input bit kept);
        if (kept) sb.push_back(model(s, cur_gain, cur_boost, cur_mode));
        bus_write(5'h06, 32'(s));
    endtask

    task automatic read_out(input string tag);
        logic [31:0] d;
        logic [31:0] e;
        e = 32'h0;
        if (sb.size() > 0) e = sb.pop_front();
        bus_read(5'h05, d);
        check(tag, d, e);
    endtask

    task automatic wait_out(input int n, input string tag);
        logic [31:0] st;
        st = '0;
        for (int i = 0; i < 100; i++) begin
            bus_read(5'h03, st);
            if (int'(st[23:16]) >= n) break;
        end
        check(tag, 32'(st[23:16]), 32'(n));
    endtask

    initial begin
        bus.avl_address = '0;
        bus.avl_read = 1'b0;
        bus.avl_write = 1'b0;
        bus.avl_writedata = '0;

        // 1: reset values
        repeat (3) @(negedge clk);
        reset = 1'b1;
        check("rst_readdata", bus.avl_readdata, 32'h0);
        check("rst_irq", 32'(bus.irq), 32'h0);
        bus_read(5'h03, rd); check("rst_status", rd, 32'h5);
        bus_read(5'h01, rd); check("rst_gain", rd, 32'd16);
        bus_read(5'h02, rd); check("rst_boost", rd, 32'h7FFF);
        bus_read(5'h04, rd); check("rst_ctrl", rd, 32'h0);
        bus_write(5'h00, 32'hFFFF_FFFF);
        bus_read(5'h00, rd); check("unmapped_00", rd, 32'h0);
        bus_read(5'h1F, rd); check("unmapped_1f", rd, 32'h0);

        // 2: gain x2, symmetric clip at 1000
        set_cfg(32, 1000, 5);
        push_sample(300, 1'b1);
        push_sample(-700, 1'b1);
        wait_out(2, "t2_count");
        read_out("t2_out0");
        read_out("t2_out1");

        // 3: asymmetric clip, then mute
        set_cfg(16, 1000, 6);
        push_sample(-700, 1'b1);
        push_sample(1200, 1'b1);
        wait_out(2, "t3_count");
        read_out("t3_out0");
        read_out("t3_out1");
        bus_write(5'h04, 32'h7); cur_mode = 3;
        push_sample(1234, 1'b1);
        wait_out(1, "t3_mute_count");
        read_out("t3_mute");
        bus_read(5'h03, rd); check("t3_status", rd, 32'h5);

        // 4: disabled, overfill the input FIFO
        bus_write(5'h04, 32'h0); cur_mode = 0;
        for (int i = 0; i < 9; i++) push_sample(i * 100 - 400, i < 8);
        bus_read(5'h03, rd); check("t4_status_full", rd, 32'h816);
        bus_write(5'h03, 32'h10);
        bus_read(5'h03, rd); check("t4_status_clr", rd, 32'h806);

        // 5: irq at level 4, drain, underflow
        bus_write(5'h04, 32'hD); cur_mode = 1;
        wait_out(4, "t5_count");
        @(negedge clk);
        check("t5_irq_set", 32'(bus.irq), 32'h1);
        bus_write(5'h04, 32'h9);
        read_out("t5_out0");
        repeat (2) @(negedge clk);
        check("t5_irq_clr", 32'(bus.irq), 32'h0);
        read_out("t5_out1");
        read_out("t5_out2");
        read_out("t5_out3");
        bus_read(5'h05, rd); check("t5_empty_read", rd, 32'h0);
        bus_read(5'h03, rd); check("t5_status_unf", rd, 32'h424);

        // 6: reset mid-processing
        bus_write(5'h04, 32'h5);
        for (int i = 0; i < 4; i++) bus_write(5'h06, 32'(50 + i));
        wait_out(2, "t6_count");
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        sb.delete();
        check("t6_readdata", bus.avl_readdata, 32'h0);
        check("t6_irq", 32'(bus.irq), 32'h0);
        bus_read(5'h03, rd); check("t6_status", rd, 32'h5);
        bus_read(5'h01, rd); check("t6_gain", rd, 32'd16);
        bus_read(5'h04, rd); check("t6_ctrl", rd, 32'h0);
        repeat (3 * TICK) @(negedge clk);
        bus_read(5'h03, rd); check("t6_status_idle", rd, 32'h5);
        check("sb_empty", 32'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
